serial_demux_1x8: RTL and testbench
===================================

Name: serial_demux_1x8

Overview:
Serial-to-parallel 1-to-8 demultiplexer: the receive-side counterpart of the 8:1 mux serializer. A 3-bit lane index steers each valid serial bit into one of 8 lanes. A completed byte moves to an output holding register, read through a valid/ready handshake. Sits between a serial link front end and byte-wide consumer logic.

Parameters:
LSB_FIRST, 1, 1: first bit of a frame lands in lane 0; 0: first bit lands in lane 7
LANES, 8, lane count; fixed at 8 (index width 3); other values unsupported

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
din  input  1  serial data bit
din_valid  input  1  din sampled this cycle when high
frame_start  input  1  realign; current cycle is the start of a new byte
out_data  output  8  assembled byte, holding register
out_valid  output  1  out_data holds an unread byte
out_ready  input  1  consumer accepts out_data when out_valid & out_ready
bit_idx  output  3  current lane index (next lane to be written)
busy  output  1  partial byte in progress (bit_idx != 0)
overrun  output  1  sticky; a completed byte was dropped
clr_ovr  input  1  synchronous clear of overrun

Behaviour:
- Reset (rst_n low, asynchronous): bit_idx=0, lane register=8'h00, out_data=8'h00, out_valid=0, overrun=0, busy=0. All state registered; no output is a combinational function of inputs.
- Lane mapping: lane = bit_idx if LSB_FIRST=1, else 7-bit_idx. On din_valid, lane register[lane] <= din; other lanes hold.
- Index: on din_valid, bit_idx <= bit_idx+1 and wraps 7->0. No change without din_valid.
- frame_start & din_valid: partial byte discarded; din written to the lane for index 0; bit_idx <= 1. Lanes 1..7 (mapped) cleared to 0.
- frame_start & !din_valid: bit_idx <= 0; lane register cleared to 0.
- Byte complete: din_valid & bit_idx==7 & !frame_start. Assembled byte = lane register with the current din merged into its lane.
- Load rule on byte complete: if out_valid==0 or out_ready==1 in that cycle, out_data <= assembled and out_valid <= 1 (latency: out_valid high in the cycle after the 8th bit is sampled). Otherwise the byte is dropped, out_data and out_valid hold, and overrun <= 1.
- Handshake: the transfer occurs when out_valid & out_ready. If no load occurs in the same cycle, out_valid <= 0 and out_data holds its value. A load and a transfer in the same cycle keep out_valid=1 with the new data, for back-to-back throughput of 1 byte per 8 valid bits.
- out_data is stable while out_valid=1 and out_ready=0.
- overrun: sticky. clr_ovr clears it. When clr_ovr and a new drop occur in the same cycle, overrun stays 1 (set wins).
- busy = (bit_idx != 0), registered with bit_idx.
- Reset mid-byte: all progress lost immediately; the first valid bit after reset lands at index 0.

Decomposition:
- Shared include header: DEMUX_LANES=8, DEMUX_IDX_W=3, and the reset values of the lane and output registers.
- Sub-module demux_1x8 (combinational): inputs en, sel[2:0]; output one-hot we[7:0]. It generates the lane write enables. The top level holds the counter, lane register, holding register and handshake.

Test Plan:
- LSB_FIRST=1, out_ready=1. Send bits 1,0,1,0,0,1,0,1 with din_valid=1 on 8 consecutive cycles -> out_data=8'hA5 and out_valid=1 in the cycle after the 8th bit; bit_idx=0; busy=0.
- LSB_FIRST=0. Same bit sequence -> out_data=8'hA5 with bit order reversed in the lanes, i.e. 8'hA5 (palindrome check), then send 1,1,0,0,0,0,0,0 -> out_data=8'hC0.
- din_valid gaps: 3 bits, 5 idle cycles, 5 bits of 0x3C LSB-first -> bit_idx holds at 3 during the gap; out_data=8'h3C.
- 4 bits of garbage, then frame_start with din_valid on the first bit of 0x81 -> out_data=8'h81, not corrupted by the garbage bits.
- out_ready=0; send 0x11 then 0x22 -> out_data stays 8'h11 and overrun=1. Pulse clr_ovr -> overrun=0. Raise out_ready -> out_valid drops the next cycle.
- Assert rst_n=0 asynchronously after 5 bits -> all outputs zero immediately. After release, 0x5A LSB-first -> out_data=8'h5A.

Source files
------------

// File: rtl/serial_demux_1x8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_demux_1x8_pkg
//  Description : Shared constants and lane-mapping helper for the 1:8 serial
//                demultiplexer.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_demux_1x8_pkg;

    localparam int         c_DEMUX_LANES = 8;
    localparam int         c_DEMUX_IDX_W = 3;
    localparam logic [7:0] c_LANE_RST    = 8'h00;
    localparam logic [7:0] c_OUT_RST     = 8'h00;
    localparam logic [2:0] c_IDX_FIRST   = 3'd0;
    localparam logic [2:0] c_IDX_LAST    = 3'd7;

    // Map a bit position within the frame to the physical lane it lands in.
    function automatic logic [2:0] mapLane(input logic [2:0] idx, input logic lsbFirst);
        return lsbFirst ? idx : (c_IDX_LAST - idx);
    endfunction

endpackage : serial_demux_1x8_pkg
`default_nettype wire

// File: rtl/serial_demux_1x8_demux.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1x8
//  Description : Combinational 1-to-8 decoder producing one-hot lane write
//                enables from a 3-bit lane select, gated by en.
//  Revision    : 1.0  initial release
// ============================================================================
module demux_1x8
    import serial_demux_1x8_pkg::*;
(
    input  logic                     en,
    input  logic [c_DEMUX_IDX_W-1:0] sel,
    output logic [c_DEMUX_LANES-1:0] we
);

    // One enable per lane; at most one is high at a time.
    for (genvar i = 0; i < c_DEMUX_LANES; i++) begin : g_lane
        assign we[i] = en && (sel == c_DEMUX_IDX_W'(i));
    end

endmodule : demux_1x8
`default_nettype wire

// File: rtl/serial_demux_1x8.sv
`default_nettype none
// ============================================================================
//  Module      : serial_demux_1x8
//  Description : Serial-to-parallel 1:8 demultiplexer. Steers valid serial
//                bits into 8 lanes, moves each completed byte into a holding
//                register read through a valid/ready handshake, and flags
//                dropped bytes with a sticky overrun.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_demux_1x8
    import serial_demux_1x8_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1,
    parameter int LANES     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [LANES-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       bit_idx,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_ovr
);

    logic [LANES-1:0] r_laneReg;
    logic [LANES-1:0] r_outData;
    logic             r_outValid;
    logic [2:0]       r_bitIdx;
    logic             r_busy;
    logic             r_overrun;

    logic [2:0]       w_idxEff;
    logic [2:0]       w_lane;
    logic [LANES-1:0] w_we;
    logic [LANES-1:0] w_laneNext;
    logic [2:0]       w_idxNext;
    logic             w_byteDone;
    logic             w_load;
    logic             w_drop;

    // frame_start realigns the frame, so the current bit is treated as index 0.
    assign w_idxEff = frame_start ? c_IDX_FIRST : r_bitIdx;
    assign w_lane   = mapLane(w_idxEff, LSB_FIRST);

    demux_1x8 u_demux (
        .en  (din_valid),
        .sel (w_lane),
        .we  (w_we)
    );

    // Next lane contents: clear on realign, then merge the incoming bit.
    always_comb begin
        w_laneNext = frame_start ? c_LANE_RST : r_laneReg;
        for (int i = 0; i < LANES; i++) begin
            if (w_we[i]) begin
                w_laneNext[i] = din;
            end
        end
    end

    // Next bit index: realign to 0/1 on frame_start, else advance on each valid bit.
    always_comb begin
        w_idxNext = r_bitIdx;
        if (frame_start) begin
            w_idxNext = din_valid ? 3'd1 : c_IDX_FIRST;
        end else if (din_valid) begin
            w_idxNext = r_bitIdx + 3'd1;
        end
    end

    // A byte completes on the 8th valid bit; it loads only if the holding register is free.
    assign w_byteDone = din_valid && (r_bitIdx == c_IDX_LAST) && !frame_start;
    assign w_load     = w_byteDone && (!r_outValid || out_ready);
    assign w_drop     = w_byteDone && !w_load;

    // Lane assembly register and frame position counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_laneReg <= c_LANE_RST;
            r_bitIdx  <= c_IDX_FIRST;
            r_busy    <= 1'b0;
        end else begin
            r_laneReg <= w_laneNext;
            r_bitIdx  <= w_idxNext;
            r_busy    <= (w_idxNext != c_IDX_FIRST);
        end
    end

    // Output holding register with valid/ready handshake; load and transfer may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outData  <= c_OUT_RST;
            r_outValid <= 1'b0;
        end else if (w_load) begin
            r_outData  <= w_laneNext;
            r_outValid <= 1'b1;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // Sticky overrun flag; a new drop takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_ovr) begin
            r_overrun <= 1'b0;
        end
    end

    assign out_data  = r_outData;
    assign out_valid = r_outValid;
    assign bit_idx   = r_bitIdx;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule : serial_demux_1x8
`default_nettype wire

// File: tb/tb_serial_demux_1x8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_demux_1x8
//  Description : Scoreboard bench driving an LSB-first and an MSB-first
//                instance of serial_demux_1x8 with the same serial stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_demux_1x8;

    logic       clk;
    logic       rstN;
    logic       din;
    logic       dinValid;
    logic       frameStart;
    logic       outReady;
    logic       clrOvr;

    logic [7:0] outDataL, outDataM;
    logic       outValidL, outValidM;
    logic [2:0] bitIdxL, bitIdxM;
    logic       busyL, busyM;
    logic       overrunL, overrunM;

    logic [7:0] qL[$];
    logic [7:0] qM[$];

    int testsRun    = 0;
    int testsFailed = 0;

    serial_demux_1x8 #(.LSB_FIRST(1'b1), .LANES(8)) dutL (
        .clk(clk), .rst_n(rstN), .din(din), .din_valid(dinValid),
        .frame_start(frameStart), .out_data(outDataL), .out_valid(outValidL),
        .out_ready(outReady), .bit_idx(bitIdxL), .busy(busyL),
        .overrun(overrunL), .clr_ovr(clrOvr)
    );

    serial_demux_1x8 #(.LSB_FIRST(1'b0), .LANES(8)) dutM (
        .clk(clk), .rst_n(rstN), .din(din), .din_valid(dinValid),
        .frame_start(frameStart), .out_data(outDataM), .out_valid(outValidM),
        .out_ready(outReady), .bit_idx(bitIdxM), .busy(busyM),
        .overrun(overrunM), .clr_ovr(clrOvr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: every accepted byte is popped from its queue and compared.
    always @(negedge clk) begin
        if (rstN && outValidL && outReady) begin
            if (qL.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("FAIL lsb_unexpected_byte: got %0h expected none", outDataL);
            end else begin
                check("lsb_byte", {24'h0, outDataL}, {24'h0, qL.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rstN && outValidM && outReady) begin
            if (qM.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("FAIL msb_unexpected_byte: got %0h expected none", outDataM);
            end else begin
                check("msb_byte", {24'h0, outDataM}, {24'h0, qM.pop_front()});
            end
        end
    end

    // Send bits b[from]..b[to] on consecutive cycles; fs marks the first as frame start.
    task automatic sendBits(input logic [7:0] b, input int from, input int to, input logic fs);
        for (int i = from; i <= to; i++) begin
            din        = b[i];
            dinValid   = 1'b1;
            frameStart = fs && (i == from);
            @(posedge clk);
            #1;
        end
        dinValid   = 1'b0;
        frameStart = 1'b0;
        din        = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rstN       = 1'b0;
        din        = 1'b0;
        dinValid   = 1'b0;
        frameStart = 1'b0;
        outReady   = 1'b1;
        clrOvr     = 1'b0;
        idle(2);

        // Reset state
        check("rst_out_data",  {24'h0, outDataL}, 32'h0);
        check("rst_out_valid", {31'h0, outValidL}, 32'h0);
        check("rst_bit_idx",   {29'h0, bitIdxL}, 32'h0);
        check("rst_busy",      {31'h0, busyL}, 32'h0);
        check("rst_overrun",   {31'h0, overrunL}, 32'h0);
        check("rst_msb_valid", {31'h0, outValidM}, 32'h0);
        rstN = 1'b1;
        idle(1);

        // A5 on both orderings (palindrome)
        qL.push_back(8'hA5); qM.push_back(8'hA5);
        sendBits(8'hA5, 0, 2, 1'b0);
        check("mid_busy", {31'h0, busyL}, 32'h1);
        sendBits(8'hA5, 3, 7, 1'b0);
        check("a5_latency_valid", {31'h0, outValidL}, 32'h1);
        check("a5_msb_valid",     {31'h0, outValidM}, 32'h1);
        check("a5_bit_idx",       {29'h0, bitIdxL}, 32'h0);
        check("a5_busy",          {31'h0, busyL}, 32'h0);
        idle(1);
        check("a5_valid_drop",    {31'h0, outValidL}, 32'h0);

        // Bits 1,1,0,0,0,0,0,0: LSB-first gives 03, MSB-first gives C0
        qL.push_back(8'h03); qM.push_back(8'hC0);
        sendBits(8'h03, 0, 7, 1'b0);
        idle(1);

        // din_valid gap mid-byte
        qL.push_back(8'h3C); qM.push_back(8'h3C);
        sendBits(8'h3C, 0, 2, 1'b0);
        check("gap_idx_start", {29'h0, bitIdxL}, 32'h3);
        idle(5);
        check("gap_idx_hold",  {29'h0, bitIdxL}, 32'h3);
        check("gap_msb_idx",   {29'h0, bitIdxM}, 32'h3);
        check("gap_busy",      {31'h0, busyL}, 32'h1);
        sendBits(8'h3C, 3, 7, 1'b0);
        idle(1);

        // Garbage then realign with frame_start
        sendBits(8'h0F, 0, 3, 1'b0);
        check("garbage_idx", {29'h0, bitIdxL}, 32'h4);
        qL.push_back(8'h81); qM.push_back(8'h81);
        sendBits(8'h81, 0, 7, 1'b1);
        check("realign_idx", {29'h0, bitIdxL}, 32'h0);
        idle(1);

        // Overrun: consumer stalled, second byte dropped
        outReady = 1'b0;
        qL.push_back(8'h11); qM.push_back(8'h88);
        sendBits(8'h11, 0, 7, 1'b0);
        check("stall_valid", {31'h0, outValidL}, 32'h1);
        check("no_ovr_yet",  {31'h0, overrunL}, 32'h0);
        sendBits(8'h22, 0, 7, 1'b0);
        check("ovr_set_lsb", {31'h0, overrunL}, 32'h1);
        check("ovr_set_msb", {31'h0, overrunM}, 32'h1);
        check("ovr_hold_data", {24'h0, outDataL}, 32'h11);
        sendBits(8'h33, 0, 6, 1'b0);
        clrOvr = 1'b1;
        sendBits(8'h33, 7, 7, 1'b0);
        clrOvr = 1'b0;
        check("ovr_set_wins", {31'h0, overrunL}, 32'h1);
        clrOvr = 1'b1;
        idle(1);
        clrOvr = 1'b0;
        check("ovr_clear_lsb", {31'h0, overrunL}, 32'h0);
        check("ovr_clear_msb", {31'h0, overrunM}, 32'h0);
        outReady = 1'b1;
        idle(1);
        check("release_valid", {31'h0, outValidL}, 32'h0);

        // Asynchronous reset mid-byte
        sendBits(8'hFF, 0, 4, 1'b0);
        check("pre_rst_idx", {29'h0, bitIdxL}, 32'h5);
        #2;
        rstN = 1'b0;
        #1;
        check("arst_out_data", {24'h0, outDataL}, 32'h0);
        check("arst_valid",    {31'h0, outValidL}, 32'h0);
        check("arst_idx",      {29'h0, bitIdxL}, 32'h0);
        check("arst_busy",     {31'h0, busyL}, 32'h0);
        check("arst_msb_idx",  {29'h0, bitIdxM}, 32'h0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        qL.push_back(8'h5A); qM.push_back(8'h5A);
        sendBits(8'h5A, 0, 7, 1'b0);
        idle(1);

        // Drain: every expected byte must have been observed
        for (int n = 0; n < 20 && (qL.size() != 0 || qM.size() != 0); n++) begin
            idle(1);
        end
        testsRun++;
        if (qL.size() != 0 || qM.size() != 0) begin
            testsFailed++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", qL.size(), qM.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_serial_demux_1x8
`default_nettype wire
